// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank drive controller.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/JKFF.sv
// Plain JK flip-flop with synchronous active-low reset.
module JKFF (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // Standard JK behaviour: hold, reset, set, toggle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_excite.sv
// Per-bit JK excitation: J/K that move one flip-flop from q to tgt.
module jk_excite #(
  parameter int DC_ONE = 0
) (
  input  logic q,
  input  logic tgt,
  output logic j,
  output logic k
);

  // With don't-cares at 1 the current state no longer matters, so the
  // q-dependent term is masked off; the toggle code can never result.
  localparam logic DC = DC_ONE[0];

  assign j = tgt & (~q | DC);
  assign k = ~tgt & (q | DC);

endmodule

// File: rtl/jk_drive_ctrl.sv
// Drives an external bank of JK flip-flops to a requested word and
// verifies the bank reached it one cycle later.
module jk_drive_ctrl #(
  parameter int WIDTH  = 4,
  parameter int DC_ONE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             err,
  output logic [7:0]       err_cnt
);

  import jk_pkg::*;

  logic [WIDTH-1:0]     exc_j;
  logic [WIDTH-1:0]     exc_k;
  state_t               state_q;
  logic [WIDTH-1:0]     tgt_r;
  logic [WIDTH-1:0]     j_q;
  logic [WIDTH-1:0]     k_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 miss;

  for (genvar g = 0; g < WIDTH; g++) begin : g_exc
    jk_excite #(.DC_ONE(DC_ONE)) u_exc (
      .q   (q_fb[g]),
      .tgt (tgt_data[g]),
      .j   (exc_j[g]),
      .k   (exc_k[g])
    );
  end

  // Miss detection and saturating next count, consumed only in CHECK.
  always_comb begin
    miss      = (q_fb != tgt_r);
    err_cnt_d = err_cnt_q;
    if (miss && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Transfer FSM with registered handshake, drive and error outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tgt_r     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tgt_valid && ready_q) begin
            tgt_r   <= tgt_data;
            j_q     <= exc_j;
            k_q     <= exc_k;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          // Bank samples j/k on this edge; release them so it holds.
          j_q     <= '0;
          k_q     <= '0;
          state_q <= CHECK;
        end
        CHECK: begin
          err_q     <= miss;
          err_cnt_q <= err_cnt_d;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          j_q     <= '0;
          k_q     <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tgt_ready = ready_q;
  assign busy      = busy_q;
  assign j         = j_q;
  assign k         = k_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Closed-loop bench: two controllers (don't-cares to 0 and to 1) each
// driving a bank of four JKFF instances.
module tb_jk_drive_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tgt_valid = 1'b0;
  logic [3:0] tgt_data = 4'b0000;
  logic       force_b0 = 1'b0;
  logic       b0_rst;

  logic [3:0] q0, j0, k0, q1, j1, k1;
  logic       ready0, busy0, err0, ready1, busy1, err1;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [3:0] vec [9] = '{4'b0011, 4'b1100, 4'b0101,
                          4'b1001, 4'b0000, 4'b1111,
                          4'b0110, 4'b1010, 4'b0001};

  always #5 clk = ~clk;

  assign b0_rst = rst & ~force_b0;

  jk_drive_ctrl #(.WIDTH(4), .DC_ONE(0)) dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(ready0), .q_fb(q0), .j(j0), .k(k0), .busy(busy0),
    .err(err0), .err_cnt(cnt0)
  );

  jk_drive_ctrl #(.WIDTH(4), .DC_ONE(1)) dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(ready1), .q_fb(q1), .j(j1), .k(k1), .busy(busy1),
    .err(err1), .err_cnt(cnt1)
  );

  for (genvar g = 0; g < 4; g++) begin : g_bank
    JKFF u_ff0 (.clk(clk), .rst((g == 0) ? b0_rst : rst), .j(j0[g]), .k(k0[g]), .q(q0[g]));
    JKFF u_ff1 (.clk(clk), .rst(rst), .j(j1[g]), .k(k1[g]), .q(q1[g]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tgt_valid = 1'b0; tgt_data = 4'b0000; force_b0 = 1'b0;
    step(); step();
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy0); end
    checks++; if ({j0, k0} !== 8'h00) begin errors++; $display("FAIL rst_jk: got %b/%b want 0000/0000", j0, k0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err0); end
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", cnt0); end
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL rst_ready1: got %b want 1", ready1); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    tgt_data = 4'b1010; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    checks++; if (j0 !== 4'b1010) begin errors++; $display("FAIL basic_j: got %b want 1010", j0); end
    checks++; if (k0 !== 4'b0000) begin errors++; $display("FAIL basic_k: got %b want 0000", k0); end
    checks++; if ({busy0, ready0} !== 2'b10) begin errors++; $display("FAIL basic_drive_hs: got busy=%b ready=%b want 1/0", busy0, ready0); end
    step();
    checks++; if (q0 !== 4'b1010) begin errors++; $display("FAIL basic_q: got %b want 1010", q0); end
    checks++; if ({j0, k0, busy0} !== 9'b000000001) begin errors++; $display("FAIL basic_check_state: got j=%b k=%b busy=%b want 0000/0000/1", j0, k0, busy0); end
    step();
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", ready0); end
  endtask

  task automatic test_dc_modes();
    tgt_data = 4'b0110; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    checks++; if ({j0, k0} !== {4'b0100, 4'b1000}) begin errors++; $display("FAIL dc0_jk: got %b/%b want 0100/1000", j0, k0); end
    checks++; if ({j1, k1} !== {4'b0110, 4'b1001}) begin errors++; $display("FAIL dc1_jk: got %b/%b want 0110/1001", j1, k1); end
    step();
    checks++; if (q0 !== 4'b0110) begin errors++; $display("FAIL dc0_q: got %b want 0110", q0); end
    checks++; if (q1 !== 4'b0110) begin errors++; $display("FAIL dc1_q: got %b want 0110", q1); end
    step();
    checks++; if ({err0, err1} !== 2'b00) begin errors++; $display("FAIL dc_err: got %b%b want 00", err0, err1); end
  endtask

  task automatic test_reset_in_drive();
    tgt_data = 4'b1111; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rd_busy_drive: got %b want 1", busy0); end
    rst = 1'b0;
    step();
    checks++; if ({busy0, ready0, err0} !== 3'b010) begin errors++; $display("FAIL rd_abort: got busy=%b ready=%b err=%b want 0/1/0", busy0, ready0, err0); end
    checks++; if ({j0, k0} !== 8'h00) begin errors++; $display("FAIL rd_jk: got %b/%b want 0000/0000", j0, k0); end
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL rd_cnt: got %0d want 0", cnt0); end
    rst = 1'b1;
    step(); step();
    checks++; if ({ready0, err0, cnt0} !== {1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL rd_after: got ready=%b err=%b cnt=%0d want 1/0/0", ready0, err0, cnt0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      tgt_data = vec[i]; tgt_valid = 1'b1;
      checks++; if (ready0 !== ((i % 3) == 0)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, ready0, ((i % 3) == 0)); end
      checks++; if (((j0 & k0) | (j1 & k1)) !== 4'b0000) begin errors++; $display("FAIL b2b_toggle[%0d]: got j0&k0=%b j1&k1=%b want 0000", i, j0 & k0, j1 & k1); end
      if ((i % 3) == 2) begin
        checks++; if (q0 !== vec[i-2]) begin errors++; $display("FAIL b2b_q[%0d]: got %b want %b", i, q0, vec[i-2]); end
      end
      if ((i % 3) == 0 && i > 0) begin
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got %b want 0", i, err0); end
      end
      step();
    end
    tgt_valid = 1'b0;
    checks++; if ({q0, err0, ready0} !== {4'b0110, 1'b0, 1'b1}) begin errors++; $display("FAIL b2b_end: got q=%b err=%b ready=%b want 0110/0/1", q0, err0, ready0); end
  endtask

  task automatic test_err_saturate();
    force_b0 = 1'b1;
    tgt_data = 4'b0001; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    step();
    checks++; if (q0[0] !== 1'b0) begin errors++; $display("FAIL err_q0: got %b want 0", q0[0]); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err0); end
    step();
    checks++; if ({err0, cnt0} !== {1'b1, 8'd1}) begin errors++; $display("FAIL err_pulse: got err=%b cnt=%0d want 1/1", err0, cnt0); end
    checks++; if ({err1, cnt1} !== {1'b0, 8'd0}) begin errors++; $display("FAIL err_dc1: got err=%b cnt=%0d want 0/0", err1, cnt1); end
    step();
    checks++; if ({err0, cnt0} !== {1'b0, 8'd1}) begin errors++; $display("FAIL err_one_cycle: got err=%b cnt=%0d want 0/1", err0, cnt0); end
    for (int n = 0; n < 259; n++) begin
      tgt_valid = 1'b1;
      step();
      tgt_valid = 1'b0;
      step(); step();
      if (n == 252) begin
        checks++; if (cnt0 !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", cnt0); end
      end
      if (n == 253) begin
        checks++; if (cnt0 !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", cnt0); end
      end
    end
    checks++; if ({err0, cnt0} !== {1'b1, 8'd255}) begin errors++; $display("FAIL sat_final: got err=%b cnt=%0d want 1/255", err0, cnt0); end
    force_b0 = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dc_modes();
    test_reset_in_drive();
    test_back_to_back();
    test_err_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jk_drive_ctrl.md
JK_DRIVE_CTRL -- requirements
Module: jk_drive_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of external JK flip-flops driven.
REQ-002 SHALL have parameter DC_ONE, default 0: don't-care resolution; 0 = don't-cares to 0, 1 = don't-cares to 1.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port tgt_valid  input  1  target word offered.
REQ-006 SHALL have port tgt_data  input  WIDTH  desired next state of the JK bank.
REQ-007 SHALL have port tgt_ready  output  1  controller can accept a target.
REQ-008 SHALL have port q_fb  input  WIDTH  q outputs fed back from the JK bank.
REQ-009 SHALL have port j  output  WIDTH  J inputs to the JK bank.
REQ-010 SHALL have port k  output  WIDTH  K inputs to the JK bank.
REQ-011 SHALL have port busy  output  1  transfer in progress.
REQ-012 SHALL have port err  output  1  one-cycle pulse: bank missed its target.
REQ-013 SHALL have port err_cnt  output  8  saturating mismatch count.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, DRIVE, CHECK.
REQ-015 IDLE: tgt_ready=1, busy=0, j=k=0 (bank holds); transfer accepted on the posedge where tgt_valid=1 and tgt_ready=1.
REQ-016 On accept, SHALL latch tgt_data into tgt_r, register j/k from excitation of (q_fb, tgt_data), and go to DRIVE.
REQ-017 Excitation per bit, DC_ONE=0: j = tgt & ~q, k = ~tgt & q.
REQ-018 Excitation per bit, DC_ONE=1: j = tgt, k = ~tgt.
REQ-019 DRIVE lasts exactly one cycle: j/k stay stable, tgt_ready=0, busy=1; the bank samples j/k on the closing edge, then the FSM goes to CHECK.
REQ-020 CHECK lasts one cycle: j=k=0, busy=1, tgt_ready=0; on its closing edge SHALL compare q_fb with tgt_r.
REQ-021 On mismatch SHALL pulse err for exactly one cycle (the cycle after CHECK) and increment err_cnt, saturating at 255.
REQ-022 After CHECK SHALL return to IDLE; throughput is one target per 3 cycles; accept-to-err latency is 3 edges.
REQ-023 tgt_data and tgt_valid SHALL be ignored outside IDLE; no queuing.
REQ-024 j and k SHALL never both be 1 on the same bit when DC_ONE=0; the toggle code is never issued in either mode.
REQ-025 A target equal to the current q_fb SHALL still perform the full IDLE->DRIVE->CHECK sequence (j=k=0 when DC_ONE=0).

Reset
REQ-026 When rst=0 at a posedge: FSM->IDLE, j=0, k=0, err=0, err_cnt=0, tgt_r=0, busy=0; tgt_ready=1 from the first cycle after reset.
REQ-027 Reset asserted in DRIVE or CHECK SHALL abort the transfer with no err pulse and no count change.
REQ-028 Reset SHALL take priority over tgt_valid on the same edge.

Structure
REQ-029 State encodings (IDLE=2'd0, DRIVE=2'd1, CHECK=2'd2) and ERR_CNT_W=8 SHALL live in shared package jk_pkg.
REQ-030 Per-bit excitation SHALL be the sub-module jk_excite (inputs q, tgt; parameter DC_ONE; outputs j, k), instantiated WIDTH times by generate.
REQ-031 The bench SHALL close the loop with WIDTH existing JKFF flip-flop instances sharing clk and rst.

Verification
REQ-032 Reset, then tgt=4'b1010 with bank q=0000, DC_ONE=0 -> DRIVE shows j=1010, k=0000; q_fb=1010 after 1 edge; no err.
REQ-033 Bank q=1010, tgt=0110, DC_ONE=0 -> j=0100, k=1000; q_fb=0110; no err; back-to-back second target accepted 3 cycles after the first.
REQ-034 Bank q=1010, tgt=0110, DC_ONE=1 -> j=0110, k=1001; q_fb=0110; no err.
REQ-035 Force the bank-bit0 rst low while targeting 0001 -> err pulses one cycle after CHECK; err_cnt 0->1; 260 forced misses -> err_cnt=255.
REQ-036 rst=0 asserted during DRIVE -> next cycle IDLE, j=k=0, err=0, err_cnt unchanged at 0, tgt_ready=1 after release.
REQ-037 tgt_valid held high throughout -> accept only in IDLE; tgt_ready pattern 1,0,0 repeating; j&k==0 on every cycle (DC_ONE=0).
